// File: rtl/snax_gemmx_csr_pkg.sv
// Shared types and address-map helpers for the GEMMX CSR manager.
package snax_gemmx_csr_pkg;

  // Launch FSM: IDLE accepts launches, LAUNCH holds the frozen set until the shell takes it.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LAUNCH = 1'b1
  } csr_mgr_state_e;

  // First RO register sits directly after the RW block.
  function automatic int unsigned ro_base(input int unsigned rw_count);
    return rw_count;
  endfunction

  // Launch register sits directly after the RO block.
  function automatic int unsigned launch_addr(input int unsigned rw_count,
                                              input int unsigned ro_count);
    return rw_count + ro_count;
  endfunction

endpackage

// File: rtl/snax_gemmx_csr_manager.sv
// CSR manager for the GEMMX shell: holds RW configuration, serves reads of
// RW/RO/launch-status registers and launches the configuration to the shell.
module snax_gemmx_csr_manager
  import snax_gemmx_csr_pkg::*;
#(
  parameter int unsigned RegRWCount   = 10,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                  csr_req_data_i,
  input  logic                                     csr_req_write_i,
  input  logic                                     csr_req_valid_i,
  output logic                                     csr_req_ready_o,
  output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
  output logic                                     csr_rsp_valid_o,
  input  logic                                     csr_rsp_ready_i,
  output logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_o,
  output logic                                     csr_reg_set_valid_o,
  input  logic                                     csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i
);

  localparam logic [RegAddrWidth-1:0] LaunchAddr =
    RegAddrWidth'(launch_addr(RegRWCount, RegROCount));
  localparam logic [RegAddrWidth-1:0] RoBase = RegAddrWidth'(ro_base(RegRWCount));

  csr_mgr_state_e                          state_q;
  logic [RegRWCount-1:0][RegDataWidth-1:0] cfg_q;
  logic [RegRWCount-1:0][RegDataWidth-1:0] set_q;
  logic                                    set_valid_q;
  logic                                    rsp_valid_q;
  logic [RegDataWidth-1:0]                 rsp_data_q;
  logic [RegDataWidth-1:0]                 rd_data_d;

  logic [RegRWCount-1:0] rw_hit;
  logic [RegROCount-1:0] ro_hit;
  logic                  launch_hit;
  logic                  req_ready;
  logic                  req_fire;
  logic                  launch_start;

  // One-hot address decode; unmapped addresses hit nothing.
  for (genvar i = 0; i < RegRWCount; i++) begin : g_rw_hit
    assign rw_hit[i] = (csr_req_addr_i == RegAddrWidth'(i));
  end
  for (genvar j = 0; j < RegROCount; j++) begin : g_ro_hit
    assign ro_hit[j] = (csr_req_addr_i == (RoBase + RegAddrWidth'(j)));
  end
  assign launch_hit = (csr_req_addr_i == LaunchAddr);

  // Stall while a response is blocked, or while a launch write would overrun an active launch.
  assign req_ready = !(rsp_valid_q && !csr_rsp_ready_i) &&
                     !(launch_hit && csr_req_write_i && (state_q == LAUNCH));
  assign req_fire  = csr_req_valid_i && req_ready;

  // Only a bit0=1 launch write in IDLE starts a launch; bit0=0 is a silent no-op.
  assign launch_start = req_fire && csr_req_write_i && launch_hit &&
                        csr_req_data_i[0] && (state_q == IDLE);

  // AND-OR read mux over the decoded hits; misses read back as zero.
  always_comb begin
    rd_data_d = {RegDataWidth{1'b0}};
    for (int i = 0; i < RegRWCount; i++) begin
      rd_data_d = rd_data_d | ({RegDataWidth{rw_hit[i]}} & cfg_q[i]);
    end
    for (int j = 0; j < RegROCount; j++) begin
      rd_data_d = rd_data_d | ({RegDataWidth{ro_hit[j]}} & csr_reg_ro_set_i[j]);
    end
    if (launch_hit) begin
      rd_data_d = rd_data_d | {{(RegDataWidth-1){1'b0}}, (state_q == LAUNCH)};
    end else begin
      rd_data_d = rd_data_d;
    end
  end

  // Configuration bank: written by the core in either FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '{default: {RegDataWidth{1'b0}}};
    end else begin
      for (int i = 0; i < RegRWCount; i++) begin
        if (req_fire && csr_req_write_i && rw_hit[i]) begin
          cfg_q[i] <= csr_req_data_i;
        end
      end
    end
  end

  // Launch FSM: snapshot cfg (pre-write values) on launch, hold until the shell accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      set_q       <= '{default: {RegDataWidth{1'b0}}};
      set_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_start) begin
            set_q       <= cfg_q;
            set_valid_q <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (csr_reg_set_ready_i) begin
            set_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          set_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Single-entry read response slot; a new read may refill it in the cycle it drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {RegDataWidth{1'b0}};
    end else if (req_fire && !csr_req_write_i) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data_d;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign csr_req_ready_o     = req_ready;
  assign csr_rsp_valid_o     = rsp_valid_q;
  assign csr_rsp_data_o      = rsp_data_q;
  assign csr_reg_set_o       = set_q;
  assign csr_reg_set_valid_o = set_valid_q;

endmodule

// File: tb/tb_snax_gemmx_csr_manager.sv
// Scoreboard bench for snax_gemmx_csr_manager: directed scenarios plus random traffic.
module tb_snax_gemmx_csr_manager;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       req_addr, req_data;
  logic              req_write, req_valid;
  logic              req_ready;
  logic [31:0]       rsp_data;
  logic              rsp_valid, rsp_ready;
  logic [9:0][31:0]  reg_set;
  logic              set_valid, set_ready;
  logic [1:0][31:0]  ro_set;

  // Environment knobs (written only by the main sequence)
  int                rsp_mode, set_mode;   // 0: always 1, 1: random, 2: held 0
  bit                ro_mode;              // 1: random RO inputs
  logic [1:0][31:0]  ro_fixed;

  // Reference model
  logic [31:0]       cfg_m [10];
  logic [9:0][31:0]  launched_m;
  bit                launch_m, rsp_pend_m;
  logic [31:0]       exp_q [$];

  int total, bad;

  always #5 clk = ~clk;

  snax_gemmx_csr_manager dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .csr_req_addr_i      (req_addr),
    .csr_req_data_i      (req_data),
    .csr_req_write_i     (req_write),
    .csr_req_valid_i     (req_valid),
    .csr_req_ready_o     (req_ready),
    .csr_rsp_data_o      (rsp_data),
    .csr_rsp_valid_o     (rsp_valid),
    .csr_rsp_ready_i     (rsp_ready),
    .csr_reg_set_o       (reg_set),
    .csr_reg_set_valid_o (set_valid),
    .csr_reg_set_ready_i (set_ready),
    .csr_reg_ro_set_i    (ro_set)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Background drivers for the response/launch ready lines and RO inputs.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
      case (set_mode)
        0:       set_ready = 1'b1;
        1:       set_ready = 1'($urandom_range(0, 1));
        default: set_ready = 1'b0;
      endcase
      if (ro_mode) ro_set = {$urandom, $urandom};
      else         ro_set = ro_fixed;
    end
  end

  // Reference model: checks ready/launch outputs and pushes expected read data on accept.
  initial begin
    logic [31:0] a, e;
    bit          exp_rdy, new_launch;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        for (int i = 0; i < 10; i++) cfg_m[i] = 32'd0;
        launched_m = '0;
        launch_m   = 1'b0;
        rsp_pend_m = 1'b0;
      end else begin
        a = req_addr;
        new_launch = 1'b0;
        exp_rdy = !(rsp_pend_m && !rsp_ready) && !(a == 32'd12 && req_write && launch_m);
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
        chk("set_valid", {31'd0, set_valid}, {31'd0, launch_m});
        for (int i = 0; i < 10; i++) chk("reg_set", reg_set[i], launched_m[i]);
        if (rsp_pend_m && rsp_ready) rsp_pend_m = 1'b0;
        if (req_valid && req_ready) begin
          if (req_write) begin
            if (a < 32'd10) cfg_m[a[3:0]] = req_data;
            else if (a == 32'd12 && req_data[0] && !launch_m) begin
              for (int i = 0; i < 10; i++) launched_m[i] = cfg_m[i];
              new_launch = 1'b1;
            end
          end else begin
            if (a < 32'd10)       e = cfg_m[a[3:0]];
            else if (a == 32'd10) e = ro_set[0];
            else if (a == 32'd11) e = ro_set[1];
            else if (a == 32'd12) e = {31'd0, launch_m};
            else                  e = 32'd0;
            exp_q.push_back(e);
            rsp_pend_m = 1'b1;
          end
        end
        if (launch_m && set_ready) launch_m = 1'b0;
        if (new_launch) launch_m = 1'b1;
      end
    end
  end

  // Response monitor: pops and compares whenever the DUT presents a read response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data", rsp_data, exp_q[0]);
        if (rsp_ready) void'(exp_q.pop_front());
      end else begin
        chk("rsp_idle", {31'd0, rsp_valid}, 32'd0);
      end
    end
  end

  // Present one request and return at the negedge where it is seen accepted.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w);
    int n;
    @(posedge clk); #1;
    req_addr = a; req_data = d; req_write = w; req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL req_timeout: addr %h never accepted", a);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    total = 0; bad = 0;
    rsp_mode = 0; set_mode = 0; ro_mode = 1'b0; ro_fixed = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_set_valid", {31'd0, set_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_reg_set0", reg_set[0], 32'd0);
    #3 rst_n = 1'b1;

    // cfg write / read-back
    for (int i = 0; i < 10; i++) req(i, 32'h10 + i, 1'b1);
    for (int i = 0; i < 10; i++) req(i, 32'd0, 1'b0);
    idle();

    // launch held for several cycles by the shell
    set_mode = 2;
    req(32'd12, 32'd1, 1'b1);
    idle();
    repeat (5) @(negedge clk);
    chk("launch_hold", {31'd0, set_valid}, 32'd1);
    for (int i = 0; i < 10; i++) chk("launch_data", reg_set[i], 32'h10 + i);
    req(32'd12, 32'd0, 1'b0);
    idle();
    set_mode = 0;
    repeat (3) @(posedge clk);
    req(32'd12, 32'd0, 1'b0);
    idle();

    // cfg write during LAUNCH, second launch stalls, then relaunches with new value
    set_mode = 2;
    req(32'd12, 32'd1, 1'b1);
    req(32'd2, 32'hAA, 1'b1);
    chk("frozen2", reg_set[2], 32'h12);
    fork
      req(32'd12, 32'd1, 1'b1);
      begin repeat (4) @(posedge clk); set_mode = 0; end
    join
    idle();
    @(negedge clk);
    chk("relaunch2", reg_set[2], 32'hAA);
    repeat (3) @(posedge clk);

    // RO read with response back-pressure
    ro_fixed[1] = 32'hDEADBEEF;
    rsp_mode = 2;
    req(32'd11, 32'd0, 1'b0);
    fork
      req(32'd0, 32'd0, 1'b0);
      begin
        repeat (3) begin @(negedge clk); chk("ro_hold", rsp_data, 32'hDEADBEEF); end
        rsp_mode = 0;
      end
    join
    idle();

    // unmapped read, RO write ignored, RO read tracks input
    req(32'd40, 32'd0, 1'b0);
    req(32'd10, 32'h55, 1'b1);
    ro_fixed[0] = 32'h1234;
    req(32'd10, 32'd0, 1'b0);
    ro_fixed[0] = 32'h4321;
    req(32'd10, 32'd0, 1'b0);
    idle();

    // random traffic
    ro_mode = 1'b1; set_mode = 1;
    for (int k = 0; k < 300; k++) begin
      rsp_mode = $urandom_range(0, 1);
      ra = $urandom_range(0, 15);
      if (ra > 32'd12) ra = $urandom;
      req(ra, $urandom, 1'($urandom_range(0, 1)));
    end
    idle();
    ro_mode = 1'b0; rsp_mode = 0; set_mode = 0;
    repeat (5) @(posedge clk);

    // asynchronous reset during a launch with a response pending
    set_mode = 2; rsp_mode = 2;
    req(32'd12, 32'd1, 1'b1);
    req(32'd3, 32'd0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, set_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_set_valid", {31'd0, set_valid}, 32'd0);
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_mode = 0; set_mode = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) req(i, 32'd0, 1'b0);
    idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snax_gemmx_csr_manager.md
# snax_gemmx_csr_manager

CSR-side counterpart of the GEMMX streamer/accelerator shell. Accepts CSR read/write requests from the Snitch core, holds the RW configuration registers and launches a configuration by driving the shell's `csr_reg_set` valid/ready handshake. Returns RW, RO (busy, performance counter) and launch-status values on reads. Sits between the core's CSR request port and the GEMMX shell wrapper.

## Interface

Parameters:
- `RegRWCount`, default 10, number of RW configuration registers driven to the shell.
- `RegROCount`, default 2, number of RO status registers read back from the shell.
- `RegDataWidth`, default 32, register width.
- `RegAddrWidth`, default 32, CSR request address width.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `csr_req_addr_i`  in  RegAddrWidth  register index.
- `csr_req_data_i`  in  RegDataWidth  write data.
- `csr_req_write_i`  in  1  1 = write, 0 = read.
- `csr_req_valid_i`  in  1  request valid.
- `csr_req_ready_o`  out  1  request accepted when valid and ready are both high.
- `csr_rsp_data_o`  out  RegDataWidth  read data.
- `csr_rsp_valid_o`  out  1  read response valid.
- `csr_rsp_ready_i`  in  1  response consumed.
- `csr_reg_set_o`  out  RegRWCount x RegDataWidth  launched configuration.
- `csr_reg_set_valid_o`  out  1  launch valid.
- `csr_reg_set_ready_i`  in  1  shell accepts the launch.
- `csr_reg_ro_set_i`  in  RegROCount x RegDataWidth  status from the shell.

## Operation

Address map:
- `0..RegRWCount-1`: RW configuration registers (`cfg`).
- `RegRWCount..RegRWCount+RegROCount-1`: RO registers.
- `LaunchAddr = RegRWCount+RegROCount`: launch register.
- Any other address: reads return 0; writes are ignored and accepted.

Registers and writes:
- The block holds two register banks: `cfg`, written by the core, and `csr_reg_set_o`, the launched copy.
- A write to a RW address updates that `cfg` entry in either state.
- A write to an RO address is ignored.

Launch FSM, states IDLE and LAUNCH:
- IDLE: a write to `LaunchAddr` with data bit0 = 1 is accepted, `cfg` is copied to `csr_reg_set_o`, and the FSM moves to LAUNCH.
- IDLE: a write to `LaunchAddr` with bit0 = 0 is accepted and has no effect.
- LAUNCH: `csr_reg_set_valid_o` is high and `csr_reg_set_o` is frozen. When `csr_reg_set_ready_i` is high, the FSM returns to IDLE.
- LAUNCH: any write to `LaunchAddr` is stalled (`csr_req_ready_o` low) until the FSM is back in IDLE.

Reads:
- RW address returns `cfg`, not the launched copy.
- RO address returns `csr_reg_ro_set_i[idx]`, sampled in the accept cycle.
- `LaunchAddr` returns `{0, state==LAUNCH}`.
- At most one read response is outstanding.
- Writes produce no response.

## Timing

Reset values: all `cfg` entries 0, `csr_reg_set_o` 0, `csr_reg_set_valid_o` 0, `csr_rsp_valid_o` 0, `csr_rsp_data_o` 0, FSM in IDLE.

Request handshake:
- `csr_req_ready_o = !(csr_rsp_valid_o && !csr_rsp_ready_i) && !(addr==LaunchAddr && write && state==LAUNCH)`.
- This is combinational. `valid` must not depend on `ready`.

Read latency:
- A read accepted in cycle t gives `csr_rsp_valid_o` high in cycle t+1.
- Response data is held stable until `csr_rsp_ready_i`.
- A response consumed in cycle t with a new read accepted in cycle t gives the next response in t+1, so back-to-back reads run at one per cycle.

Write latency:
- A `cfg` write accepted in cycle t is visible to a read accepted in t+1.
- A launch accepted in cycle t gives `csr_reg_set_valid_o` and the new `csr_reg_set_o` in t+1.
- A `cfg` write accepted in the same cycle as the launch is not included in that launch (the copy uses pre-write values).

Launch handshake:
- If `csr_reg_set_valid_o` and `csr_reg_set_ready_i` are both high in cycle t, `csr_reg_set_valid_o` is low in t+1.
- A launch write pending in cycle t is accepted in t+1 at the earliest.
- Valid stays high, with no drop, while ready is low.

Reset: asserting `rst_ni` mid-launch or mid-response clears valid outputs immediately (asynchronous) and returns the FSM to IDLE.

## Structure

- Package `snax_gemmx_csr_pkg` holds:
  - the state enum `csr_mgr_state_e` {IDLE, LAUNCH};
  - the address-offset function or constant for `LaunchAddr`;
  - the RO base offset.
- Single module, no sub-module. The read-response slot is an internal one-entry register.

## Test plan

- Write `cfg[0..9] = 0x10+i`, read all back → each read returns `0x10+i` one cycle after accept; `csr_reg_set_valid_o` stays 0.
- Write `LaunchAddr = 1` with `csr_reg_set_ready_i = 0` for 5 cycles, then 1 → valid high for 6 cycles and `csr_reg_set_o[i] = 0x10+i` throughout. Reading `LaunchAddr` returns 1 during the launch and 0 after.
- While in LAUNCH, write `cfg[2] = 0xAA` and a second launch → `cfg` write accepted and `csr_reg_set_o[2]` unchanged. The second launch is stalled until the handshake, then relaunches with `[2] = 0xAA`.
- `csr_reg_ro_set_i[1] = 0xDEAD_BEEF`, read address 11 with `csr_rsp_ready_i` low for 3 cycles → response held at `0xDEADBEEF` and `csr_req_ready_o` low until consumed.
- Read address 40 → returns 0. Write address 10 → `csr_reg_ro_set_i` is unaffected and the next read of address 10 tracks the input.
- Assert `rst_ni` low during LAUNCH → `csr_reg_set_valid_o` goes 0 without waiting for a clock edge, and all `cfg` reads return 0 after reset.
